// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and default sizes for the regfile_sb register file
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_TAGW  = 4;
  localparam int DEF_NRD   = 2;

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - CLEAR/IDLE sequencer; sweeps every entry to zero after reset or clr_i
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          reset_n,
  input  logic          clr_i,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_o    = 1'b0;
    clr_we_o   = 1'b0;
    clr_addr_o = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) state_d = RF_IDLE;
      end
      RF_IDLE: begin
        ready_o = 1'b1;
        if (clr_i) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with tags, issue scoreboard and sweep clear
// Optional same-cycle write forwarding on the read ports: RF_BYPASS_EN
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = DEF_NRD,
  parameter int TAGW  = DEF_TAGW
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              clr_i,
  output logic              ready_o,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD*TAGW-1:0] rtag_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [TAGW-1:0]   wtag_i,
  input  logic              iss_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [XLEN-1:0]   dbg_data_o,
  output logic [TAGW-1:0]   dbg_tag_o
);

  logic [XLEN-1:0]  data_mem [NREGS];
  logic [TAGW-1:0]  tag_mem  [NREGS];
  logic [NREGS-1:0] busy_q;
  logic             ready;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_ok;
  logic             iss_ok;

  rf_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clear_seq (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .clr_i      (clr_i),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign ready_o = ready;
  // A clr_i accepted in IDLE swallows any write/issue of the same cycle
  assign wr_ok   = ready && !clr_i && we_i  && (waddr_i    != '0);
  assign iss_ok  = ready && !clr_i && iss_i && (iss_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      data_mem[clr_addr] <= '0;
      tag_mem[clr_addr]  <= '0;
    end else if (wr_ok) begin
      data_mem[waddr_i] <= wdata_i;
      tag_mem[waddr_i]  <= wtag_i;
    end
  end

  // Issue is applied after writeback so a new producer wins on the same address
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else if (ready && clr_i) begin
      busy_q <= '0;
    end else begin
      if (wr_ok)  busy_q[waddr_i]    <= 1'b0;
      if (iss_ok) busy_q[iss_addr_i] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic [TAGW-1:0] rt;
    logic            rb;

    assign ra = raddr_i[k*AW +: AW];

    always_comb begin
      rd = '0;
      rt = '0;
      rb = 1'b0;
      if (ready && (ra != '0)) begin
        rd = data_mem[ra];
        rt = tag_mem[ra];
        rb = busy_q[ra];
`ifdef RF_BYPASS_EN
        if (we_i && (waddr_i == ra)) begin
          rd = wdata_i;
          rt = wtag_i;
          rb = iss_i && (iss_addr_i == ra);
        end
`endif
      end
    end

    assign rdata_o[k*XLEN +: XLEN] = rd;
    assign rtag_o[k*TAGW +: TAGW]  = rt;
    assign rbusy_o[k]              = rb;
  end

  always_comb begin
    dbg_data_o = '0;
    dbg_tag_o  = '0;
    if (ready && (dbg_addr_i != '0)) begin
      dbg_data_o = data_mem[dbg_addr_i];
      dbg_tag_o  = tag_mem[dbg_addr_i];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard testbench for regfile_sb
module tb_regfile_sb;

  logic        clk;
  logic        reset_n;
  logic        clr_i;
  logic        ready_o;
  logic [7:0]  raddr_i;
  logic [63:0] rdata_o;
  logic [7:0]  rtag_o;
  logic [1:0]  rbusy_o;
  logic        we_i;
  logic [3:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wtag_i;
  logic        iss_i;
  logic [3:0]  iss_addr_i;
  logic [3:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;
  logic [3:0]  dbg_tag_o;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q[$];
  logic [36:0] e;
  logic [31:0] m_data[16];
  logic [3:0]  m_tag[16];
  logic [15:0] m_busy;

  logic [36:0] obs0, obs1, obsd;
  assign obs0 = {rdata_o[31:0],  rtag_o[3:0], rbusy_o[0]};
  assign obs1 = {rdata_o[63:32], rtag_o[7:4], rbusy_o[1]};
  assign obsd = {dbg_data_o, dbg_tag_o, 1'b0};

  regfile_sb dut (
    .clk_i      (clk),
    .reset_n    (reset_n),
    .clr_i      (clr_i),
    .ready_o    (ready_o),
    .raddr_i    (raddr_i),
    .rdata_o    (rdata_o),
    .rtag_o     (rtag_o),
    .rbusy_o    (rbusy_o),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .wtag_i     (wtag_i),
    .iss_i      (iss_i),
    .iss_addr_i (iss_addr_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o),
    .dbg_tag_o  (dbg_tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] pk(logic [31:0] d, logic [3:0] t, logic b);
    return {d, t, b};
  endfunction

  task automatic test_reset;
    int lo;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready_o, rbusy_o, rdata_o, rtag_o, dbg_data_o, dbg_tag_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b busy=%b data=%h tag=%h dbg=%h/%h required all zero",
               ready_o, rbusy_o, rdata_o, rtag_o, dbg_data_o, dbg_tag_o);
    end
    reset_n = 1'b1;
    lo = 0;
    while (ready_o === 1'b0 && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    checks++;
    if (lo !== 16) begin
      failures++;
      $display("FAIL reset_sweep_len got=%0d required=16", lo);
    end
    for (int a = 0; a < 16; a++) begin
      m_data[a] = '0;
      m_tag[a]  = '0;
    end
    m_busy = '0;
    for (int a = 0; a < 16; a++) begin
      raddr_i = {4'(15 - a), 4'(a)};
      dbg_addr_i = 4'(a);
      exp_q.push_back(pk(m_data[a], m_tag[a], m_busy[a]));
      exp_q.push_back(pk(m_data[15-a], m_tag[15-a], m_busy[15-a]));
      exp_q.push_back(pk(m_data[a], m_tag[a], 1'b0));
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL reset_read0 addr=%0d got=%h required=%h", a, obs0, e); end
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin failures++; $display("FAIL reset_read1 addr=%0d got=%h required=%h", 15 - a, obs1, e); end
      e = exp_q.pop_front(); checks++;
      if (obsd !== e) begin failures++; $display("FAIL reset_dbg addr=%0d got=%h required=%h", a, obsd, e); end
    end
  endtask

  task automatic test_write;
    @(negedge clk);
    we_i = 1'b1; waddr_i = 4'd5; wdata_i = 32'hDEADBEEF; wtag_i = 4'h3;
    raddr_i = {4'd5, 4'd5};
`ifdef RF_BYPASS_EN
    exp_q.push_back(pk(32'hDEADBEEF, 4'h3, 1'b0));
`else
    exp_q.push_back(pk(m_data[5], m_tag[5], m_busy[5]));
`endif
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL write_same_cycle got=%h required=%h", obs0, e); end
    m_data[5] = 32'hDEADBEEF; m_tag[5] = 4'h3; m_busy[5] = 1'b0;
    exp_q.push_back(pk(m_data[5], m_tag[5], m_busy[5]));
    exp_q.push_back(pk(m_data[5], m_tag[5], m_busy[5]));
    @(negedge clk);
    we_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL write_next_port0 got=%h required=%h", obs0, e); end
    e = exp_q.pop_front(); checks++;
    if (obs1 !== e) begin failures++; $display("FAIL write_next_port1 got=%h required=%h", obs1, e); end
    dbg_addr_i = 4'd5;
    exp_q.push_back(pk(m_data[5], m_tag[5], 1'b0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obsd !== e) begin failures++; $display("FAIL dbg_read got=%h required=%h", obsd, e); end
  endtask

  task automatic test_busy;
    @(negedge clk);
    iss_i = 1'b1; iss_addr_i = 4'd7; raddr_i = {4'd7, 4'd7};
    m_busy[7] = 1'b1;
    exp_q.push_back(pk(m_data[7], m_tag[7], 1'b1));
    @(negedge clk);
    iss_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL iss_sets_busy got=%h required=%h", obs0, e); end
    repeat (2) @(negedge clk);
    we_i = 1'b1; waddr_i = 4'd7; wdata_i = 32'hA5A5_0001; wtag_i = 4'h6;
`ifdef RF_BYPASS_EN
    exp_q.push_back(pk(32'hA5A5_0001, 4'h6, 1'b0));
`else
    exp_q.push_back(pk(m_data[7], m_tag[7], 1'b1));
`endif
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL wb_same_cycle got=%h required=%h", obs0, e); end
    m_data[7] = 32'hA5A5_0001; m_tag[7] = 4'h6; m_busy[7] = 1'b0;
    exp_q.push_back(pk(m_data[7], m_tag[7], m_busy[7]));
    @(negedge clk);
    we_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL wb_clears_busy got=%h required=%h", obs0, e); end
    we_i = 1'b1; waddr_i = 4'd7; wdata_i = 32'h0BAD_F00D; wtag_i = 4'h9;
    iss_i = 1'b1; iss_addr_i = 4'd7;
`ifdef RF_BYPASS_EN
    exp_q.push_back(pk(32'h0BAD_F00D, 4'h9, 1'b1));
`else
    exp_q.push_back(pk(m_data[7], m_tag[7], m_busy[7]));
`endif
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL iss_we_same_cycle got=%h required=%h", obs0, e); end
    m_data[7] = 32'h0BAD_F00D; m_tag[7] = 4'h9; m_busy[7] = 1'b1;
    exp_q.push_back(pk(m_data[7], m_tag[7], m_busy[7]));
    @(negedge clk);
    we_i = 1'b0; iss_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL iss_we_new_producer got=%h required=%h", obs0, e); end
  endtask

  task automatic test_zero;
    @(negedge clk);
    we_i = 1'b1; waddr_i = 4'd0; wdata_i = 32'hFFFF_FFFF; wtag_i = 4'hF;
    iss_i = 1'b1; iss_addr_i = 4'd0;
    raddr_i = {4'd0, 4'd0}; dbg_addr_i = 4'd0;
    exp_q.push_back(pk(32'h0, 4'h0, 1'b0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL zero_same_cycle got=%h required=%h", obs0, e); end
    exp_q.push_back(pk(32'h0, 4'h0, 1'b0));
    exp_q.push_back(pk(32'h0, 4'h0, 1'b0));
    @(negedge clk);
    we_i = 1'b0; iss_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL zero_read got=%h required=%h", obs0, e); end
    e = exp_q.pop_front(); checks++;
    if (obsd !== e) begin failures++; $display("FAIL zero_dbg got=%h required=%h", obsd, e); end
  endtask

  task automatic test_clear;
    int lo;
    @(negedge clk);
    we_i = 1'b1; waddr_i = 4'd9; wdata_i = 32'h0000_1234; wtag_i = 4'h2;
    raddr_i = {4'd7, 4'd9};
    exp_q.push_back(pk(32'h0000_1234, 4'h2, 1'b0));
    @(negedge clk);
    we_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL clear_prewrite got=%h required=%h", obs0, e); end
    clr_i = 1'b1;
    we_i = 1'b1; waddr_i = 4'd10; wdata_i = 32'h99; wtag_i = 4'h1;
    @(negedge clk);
    clr_i = 1'b0; we_i = 1'b0;
    lo = 0;
    while (ready_o === 1'b0 && lo < 100) begin
      if (lo == 3) begin
        we_i = 1'b1; waddr_i = 4'd2; wdata_i = 32'h5555; wtag_i = 4'h1;
      end else begin
        we_i = 1'b0;
      end
      if (lo == 5) begin
        exp_q.push_back(pk(32'h0, 4'h0, 1'b0));
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs0 !== e) begin failures++; $display("FAIL sweep_forced_zero got=%h required=%h", obs0, e); end
      end
      lo++;
      @(negedge clk);
    end
    we_i = 1'b0;
    checks++;
    if (lo !== 16) begin
      failures++;
      $display("FAIL clear_sweep_len got=%0d required=16", lo);
    end
    for (int a = 0; a < 16; a++) begin
      m_data[a] = '0;
      m_tag[a]  = '0;
    end
    m_busy = '0;
    for (int a = 0; a < 16; a++) begin
      raddr_i = {4'(15 - a), 4'(a)};
      exp_q.push_back(pk(m_data[a], m_tag[a], m_busy[a]));
      exp_q.push_back(pk(m_data[15-a], m_tag[15-a], m_busy[15-a]));
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL clear_read0 addr=%0d got=%h required=%h", a, obs0, e); end
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin failures++; $display("FAIL clear_read1 addr=%0d got=%h required=%h", 15 - a, obs1, e); end
    end
  endtask

  task automatic test_reset_mid;
    int lo;
    @(negedge clk);
    we_i = 1'b1; waddr_i = 4'd3; wdata_i = 32'h0000_0033; wtag_i = 4'hA;
    @(negedge clk);
    waddr_i = 4'd12; wdata_i = 32'h0000_C0C0;
    raddr_i = {4'd12, 4'd3};
    exp_q.push_back(pk(32'h0000_0033, 4'hA, 1'b0));
    @(negedge clk);
    we_i = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs0 !== e) begin failures++; $display("FAIL mid_prewrite got=%h required=%h", obs0, e); end
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    lo = 0;
    while (ready_o === 1'b0 && lo < 6) begin
      lo++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b required=0", ready_o); end
    reset_n = 1'b1;
    lo = 0;
    while (ready_o === 1'b0 && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    checks++;
    if (lo !== 16) begin
      failures++;
      $display("FAIL mid_sweep_len got=%0d required=16", lo);
    end
    for (int a = 0; a < 16; a++) begin
      raddr_i = {4'(15 - a), 4'(a)};
      exp_q.push_back(pk(32'h0, 4'h0, 1'b0));
      exp_q.push_back(pk(32'h0, 4'h0, 1'b0));
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e) begin failures++; $display("FAIL mid_read0 addr=%0d got=%h required=%h", a, obs0, e); end
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin failures++; $display("FAIL mid_read1 addr=%0d got=%h required=%h", 15 - a, obs1, e); end
    end
  endtask

  initial begin
    reset_n = 1'b0; clr_i = 1'b0; raddr_i = '0;
    we_i = 1'b0; waddr_i = '0; wdata_i = '0; wtag_i = '0;
    iss_i = 1'b0; iss_addr_i = '0; dbg_addr_i = '0;
    test_reset();
    test_write();
    test_busy();
    test_zero();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with per-register tag field, issue scoreboard and sweep-based clear for the RV32E201X core. It serves NRD combinational read ports and one write port at the decode/writeback boundary. It tracks which architectural registers have an outstanding producer, and zeroes its storage with a counter-driven sweep instead of a wide asynchronous reset. A debug read port exposes any entry and its tag to the trace/observation logic.

## Interface
- XLEN, 32, data width
- NREGS, 16, register count (RV32E); power of two, 4..32
- AW, $clog2(NREGS), address width (derived)
- NRD, 2, number of read ports, 1..4
- TAGW, 4, per-register tag width (sign/position metadata)

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clr_i  in  1  request a clear sweep (sampled only when ready_o=1)
- ready_o  out  1  1 = idle and accepting traffic; 0 = sweep in progress
- raddr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rdata_o  out  NRD*XLEN  read data per port
- rtag_o  out  NRD*TAGW  read tag per port
- rbusy_o  out  NRD  1 = addressed register has an outstanding producer
- we_i  in  1  writeback enable
- waddr_i  in  AW  writeback address
- wdata_i  in  XLEN  writeback data
- wtag_i  in  TAGW  writeback tag
- iss_i  in  1  destination issued; mark iss_addr_i busy
- iss_addr_i  in  AW  issued destination address
- dbg_addr_i  in  AW  debug read address
- dbg_data_o  out  XLEN  debug read data
- dbg_tag_o  out  TAGW  debug read tag

## Operation
- FSM states: CLEAR, IDLE. reset_n low: state=CLEAR, sweep counter=0, all busy bits=0. Data and tag arrays are not reset directly.
- CLEAR: each cycle writes data=0 and tag=0 to entry[cnt], then cnt+1. After writing entry NREGS-1, next state is IDLE. ready_o=0 throughout. we_i, iss_i and clr_i are ignored. rdata_o, rtag_o, rbusy_o, dbg_data_o and dbg_tag_o are forced to 0.
- IDLE: ready_o=1. clr_i=1 sets busy bits to 0 and cnt to 0, and moves to CLEAR. we_i/iss_i in that same cycle are ignored.
- Write: we_i and waddr_i≠0 write data and tag, and clear busy[waddr_i].
- Issue: iss_i and iss_addr_i≠0 set busy[iss_addr_i].
- Same address with iss_i and we_i in one cycle: data/tag written, busy ends 1 (new producer wins).
- Entry 0: always reads data 0, tag 0, busy 0. Writes and issues to it are dropped.
- Reads are combinational from array state.
- Out-of-range addresses (≥NREGS) are impossible by width. AW is exact because NREGS is a power of two.

## Timing
- Read latency 0 (combinational). Write visible on read ports the cycle after the we_i edge; with bypass, the same cycle.
- Busy set/clear is visible on rbusy_o the cycle after the edge.
- Sweep length is exactly NREGS cycles. ready_o rises in cycle NREGS after reset release or after the clr_i edge.
- Reset values: ready_o=0, rbusy_o=0, rdata_o=0, rtag_o=0, dbg_data_o=0, dbg_tag_o=0.
- reset_n asserted mid-sweep restarts the sweep from entry 0.

## Configuration
- RF_BYPASS_EN defined: on read port k, when in IDLE with we_i=1, waddr_i=raddr_k≠0:
  - rdata_o=wdata_i, rtag_o=wtag_i, rbusy_o=0.
  - If iss_i targets the same address in the same cycle, rbusy_o=1.
  - The debug port is never bypassed.
- Undefined: no forwarding; all reads reflect registered state only.

## Structure
- Package rf_pkg: state enum (RF_CLEAR, RF_IDLE) and default parameter constants (XLEN, NREGS, TAGW).
- Sub-module rf_clear_seq: CLEAR/IDLE FSM plus sweep counter. Outputs ready_o, clear write enable and clear address. The parent muxes the clear write against the normal write.

## Test plan
- Reset release → ready_o=0 for exactly 16 cycles (NREGS=16), then 1; all reads return 0, tag 0, busy 0.
- IDLE: we_i, waddr=5, wdata=0xDEADBEEF, wtag=0x3 → next cycle raddr0=5 gives 0xDEADBEEF/0x3. Check same-cycle value with and without RF_BYPASS_EN.
- iss_i to addr 7 → rbusy for 7 =1 next cycle; we_i to 7 three cycles later → rbusy=0 the following cycle. Same-cycle iss_i+we_i to 7 → busy stays 1, data updated.
- we_i and iss_i to addr 0 with data 0xFFFFFFFF → reads of 0 stay 0, busy 0.
- Write 0x1234 to addr 9, pulse clr_i → ready_o=0 for 16 cycles; a we_i during the sweep is ignored; afterwards addr 9 reads 0 and all busy bits are 0.
- Assert reset_n low at sweep cycle 6, release → full 16-cycle sweep restarts; entries written before the reset read 0 afterwards.
